// File: rtl/ciq_pkg.sv
// ciq_pkg: shared integer issue queue types, default sizes and the hardwired-zero tag
package ciq_pkg;
  localparam int ISSUE_NUM = 4;
  localparam int PRF_WIDTH = 6;
  localparam int CIQ_DEPTH = 16;
  localparam logic [PRF_WIDTH-1:0] ZERO_TAG = '0;
  typedef struct packed {
    logic                 valid;
    logic [PRF_WIDTH-1:0] prs1;
    logic [PRF_WIDTH-1:0] prs2;
    logic [PRF_WIDTH-1:0] prd;
    logic                 r1;
    logic                 r2;
  } ciq_entry_t;
endpackage

// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: dispatch, wake-tag, FU-ready and issue/tag-broadcast bundle of the issue queue
interface int_issue_queue_if #(
  parameter int ISSUE_NUM = ciq_pkg::ISSUE_NUM,
  parameter int CIQ_DEPTH = ciq_pkg::CIQ_DEPTH,
  parameter int PRF_WIDTH = ciq_pkg::PRF_WIDTH,
  parameter int ADDR_W = $clog2(CIQ_DEPTH)
);
  logic                                flush;
  logic                                disp_valid;
  logic                                disp_ready;
  logic [PRF_WIDTH-1:0]                disp_prs1;
  logic [PRF_WIDTH-1:0]                disp_prs2;
  logic [PRF_WIDTH-1:0]                disp_prd;
  logic                                disp_prs1_rdy;
  logic                                disp_prs2_rdy;
  logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] ciq_prs1;
  logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] ciq_prs2;
  logic [CIQ_DEPTH-1:0]                prs1_rdy;
  logic [CIQ_DEPTH-1:0]                prs2_rdy;
  logic [ISSUE_NUM-1:0]                fu_ready;
  logic [ISSUE_NUM-1:0]                arbit_grant;
  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] arbit_prd;
  logic [ISSUE_NUM-1:0][ADDR_W-1:0]    arbit_addr;
  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] arbit_prs1;
  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] arbit_prs2;
  modport master (
    output flush, disp_valid, disp_prs1, disp_prs2, disp_prd, disp_prs1_rdy, disp_prs2_rdy,
           prs1_rdy, prs2_rdy, fu_ready,
    input  disp_ready, ciq_prs1, ciq_prs2, arbit_grant, arbit_prd, arbit_addr, arbit_prs1, arbit_prs2
  );
  modport slave (
    input  flush, disp_valid, disp_prs1, disp_prs2, disp_prd, disp_prs1_rdy, disp_prs2_rdy,
           prs1_rdy, prs2_rdy, fu_ready,
    output disp_ready, ciq_prs1, ciq_prs2, arbit_grant, arbit_prd, arbit_addr, arbit_prs1, arbit_prs2
  );
endinterface

// File: rtl/ciq_select.sv
// ciq_select: maps ascending-index ready requests onto ready issue ports as per-port one-hot selects
module ciq_select #(
  parameter int ISSUE_NUM = ciq_pkg::ISSUE_NUM,
  parameter int CIQ_DEPTH = ciq_pkg::CIQ_DEPTH
) (
  input  logic [CIQ_DEPTH-1:0]                req,
  input  logic [ISSUE_NUM-1:0]                fu_ready,
  output logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] sel,
  output logic [ISSUE_NUM-1:0]                gnt
);
  logic [CIQ_DEPTH-1:0] rem;
  always_comb begin
    rem = req;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      sel[k] = fu_ready[k] ? rem & -rem : '0;
      gnt[k] = |sel[k];
      rem = rem & ~sel[k];
    end
  end
endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: centralized integer issue queue; clk, rst plus bus (dispatch in, wake in, fu_ready in, tag broadcast/issue out)
module int_issue_queue
  import ciq_pkg::ciq_entry_t, ciq_pkg::ZERO_TAG, ciq_pkg::PRF_WIDTH;
#(
  parameter int ISSUE_NUM = ciq_pkg::ISSUE_NUM,
  parameter int CIQ_DEPTH = ciq_pkg::CIQ_DEPTH,
  parameter int ADDR_W = $clog2(CIQ_DEPTH)
) (
  input logic              clk,
  input logic              rst,
  int_issue_queue_if.slave bus
);
  ciq_entry_t [CIQ_DEPTH-1:0]          ent_q, ent_d;
  logic [CIQ_DEPTH-1:0]                free, alloc, req;
  logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] sel;
  logic [ISSUE_NUM-1:0]                gnt, grant_q;
  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] prd_q, prd_d, prs1_q, prs1_d, prs2_q, prs2_d;
  logic [ISSUE_NUM-1:0][ADDR_W-1:0]    addr_q, addr_d;
  logic                                ready, fire, byp1, byp2;
  ciq_select #(.ISSUE_NUM(ISSUE_NUM), .CIQ_DEPTH(CIQ_DEPTH)) u_select (
    .req(req), .fu_ready(bus.fu_ready), .sel(sel), .gnt(gnt)
  );
  always_comb begin
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      free[i] = !ent_q[i].valid;
      req[i] = ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2;
      bus.ciq_prs1[i] = ent_q[i].prs1;
      bus.ciq_prs2[i] = ent_q[i].prs2;
    end
  end
  always_comb begin
    alloc = free & -free;
    ready = !bus.flush && |free;
    fire = bus.disp_valid && ready;
    byp1 = bus.disp_prs1_rdy || bus.disp_prs1 == ZERO_TAG;
    byp2 = bus.disp_prs2_rdy || bus.disp_prs2 == ZERO_TAG;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      byp1 = byp1 || (grant_q[k] && prd_q[k] == bus.disp_prs1);
      byp2 = byp2 || (grant_q[k] && prd_q[k] == bus.disp_prs2);
    end
  end
  always_comb begin
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      ent_d[i].r1 = ent_q[i].r1 || (ent_q[i].valid && bus.prs1_rdy[i]);
      ent_d[i].r2 = ent_q[i].r2 || (ent_q[i].valid && bus.prs2_rdy[i]);
      for (int k = 0; k < ISSUE_NUM; k++)
        if (sel[k][i]) ent_d[i].valid = 1'b0;
      if (fire && alloc[i]) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].prs1 = bus.disp_prs1;
        ent_d[i].prs2 = bus.disp_prs2;
        ent_d[i].prd = bus.disp_prd;
        ent_d[i].r1 = byp1;
        ent_d[i].r2 = byp2;
      end
      if (bus.flush) ent_d[i].valid = 1'b0;
    end
  end
  always_comb begin
    for (int k = 0; k < ISSUE_NUM; k++) begin
      prd_d[k] = prd_q[k];
      prs1_d[k] = prs1_q[k];
      prs2_d[k] = prs2_q[k];
      addr_d[k] = addr_q[k];
      for (int i = 0; i < CIQ_DEPTH; i++)
        if (sel[k][i]) begin
          prd_d[k] = ent_q[i].prd;
          prs1_d[k] = ent_q[i].prs1;
          prs2_d[k] = ent_q[i].prs2;
          addr_d[k] = ADDR_W'(i);
        end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ent_q <= '0;
      grant_q <= '0;
      prd_q <= '0;
      prs1_q <= '0;
      prs2_q <= '0;
      addr_q <= '0;
    end else begin
      ent_q <= ent_d;
      grant_q <= bus.flush ? '0 : gnt;
      prd_q <= prd_d;
      prs1_q <= prs1_d;
      prs2_q <= prs2_d;
      addr_q <= addr_d;
    end
  assign bus.disp_ready = ready;
  assign bus.arbit_grant = grant_q;
  assign bus.arbit_prd = prd_q;
  assign bus.arbit_prs1 = prs1_q;
  assign bus.arbit_prs2 = prs2_q;
  assign bus.arbit_addr = addr_q;
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_int_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  int_issue_queue_if bus();
  int_issue_queue dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] m_v, m_r1, m_r2;
  logic [5:0]  m_p1 [16];
  logic [5:0]  m_p2 [16];
  logic [5:0]  m_pd [16];
  logic [3:0]  m_g;
  logic [5:0]  m_prd [4];
  logic [5:0]  m_s1 [4];
  logic [5:0]  m_s2 [4];
  logic [3:0]  m_addr [4];
  function automatic logic exp_ready();
    return !bus.flush && (m_v != 16'hFFFF);
  endfunction
  task automatic model_reset();
    m_v = '0; m_r1 = '0; m_r2 = '0; m_g = '0;
    for (int i = 0; i < 16; i++) begin m_p1[i] = '0; m_p2[i] = '0; m_pd[i] = '0; end
    for (int k = 0; k < 4; k++) begin m_prd[k] = '0; m_s1[k] = '0; m_s2[k] = '0; m_addr[k] = '0; end
  endtask
  task automatic model_step();
    int cand[$];
    logic [15:0] nv, nr1, nr2;
    logic [3:0] ng;
    logic b1, b2, go;
    int f;
    b1 = bus.disp_prs1_rdy || bus.disp_prs1 == 6'd0;
    b2 = bus.disp_prs2_rdy || bus.disp_prs2 == 6'd0;
    for (int k = 0; k < 4; k++) begin
      if (m_g[k] && m_prd[k] == bus.disp_prs1) b1 = 1'b1;
      if (m_g[k] && m_prd[k] == bus.disp_prs2) b2 = 1'b1;
    end
    go = bus.disp_valid && exp_ready();
    nv = m_v; nr1 = m_r1; nr2 = m_r2; ng = '0;
    for (int i = 0; i < 16; i++) begin
      if (m_v[i] && m_r1[i] && m_r2[i]) cand.push_back(i);
      if (m_v[i] && bus.prs1_rdy[i]) nr1[i] = 1'b1;
      if (m_v[i] && bus.prs2_rdy[i]) nr2[i] = 1'b1;
    end
    for (int k = 0; k < 4; k++)
      if (bus.fu_ready[k] && cand.size() > 0) begin
        f = cand.pop_front();
        ng[k] = 1'b1;
        m_prd[k] = m_pd[f]; m_s1[k] = m_p1[f]; m_s2[k] = m_p2[f]; m_addr[k] = 4'(f);
        nv[f] = 1'b0;
      end
    if (go) begin
      f = 0;
      while (m_v[f]) f++;
      nv[f] = 1'b1;
      m_p1[f] = bus.disp_prs1; m_p2[f] = bus.disp_prs2; m_pd[f] = bus.disp_prd;
      nr1[f] = b1; nr2[f] = b2;
    end
    if (bus.flush) begin nv = '0; ng = '0; end
    m_v = nv; m_r1 = nr1; m_r2 = nr2; m_g = ng;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clr();
    bus.flush = 1'b0; bus.disp_valid = 1'b0;
    bus.disp_prs1 = '0; bus.disp_prs2 = '0; bus.disp_prd = '0;
    bus.disp_prs1_rdy = 1'b0; bus.disp_prs2_rdy = 1'b0;
    bus.prs1_rdy = '0; bus.prs2_rdy = '0; bus.fu_ready = 4'hF;
  endtask
  task automatic disp(input logic [5:0] p1, input logic [5:0] p2, input logic [5:0] pd, input logic r1, input logic r2);
    bus.disp_valid = 1'b1;
    bus.disp_prs1 = p1; bus.disp_prs2 = p2; bus.disp_prd = pd;
    bus.disp_prs1_rdy = r1; bus.disp_prs2_rdy = r2;
  endtask
  task automatic drain();
    clr();
    bus.flush = 1'b1;
    tick();
    clr();
  endtask
  task automatic test_reset();
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL reset_grant got=%b exp=0000", bus.arbit_grant); else n_pass++;
    n_total++; if (bus.arbit_prd !== '0) $display("FAIL reset_prd got=%h exp=0", bus.arbit_prd); else n_pass++;
    n_total++; if (bus.arbit_addr !== '0) $display("FAIL reset_addr got=%h exp=0", bus.arbit_addr); else n_pass++;
    n_total++; if (bus.ciq_prs1 !== '0 || bus.ciq_prs2 !== '0) $display("FAIL reset_ciq got=%h/%h exp=0", bus.ciq_prs1, bus.ciq_prs2); else n_pass++;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.disp_ready !== 1'b1) $display("FAIL reset_disp_ready got=%b exp=1", bus.disp_ready); else n_pass++;
  endtask
  task automatic test_basic();
    clr();
    disp(6'd5, 6'd6, 6'd10, 1'b1, 1'b1);
    tick();
    clr();
    n_total++; if (bus.ciq_prs1[0] !== 6'd5 || bus.ciq_prs2[0] !== 6'd6) $display("FAIL basic_tags got=%0d/%0d exp=5/6", bus.ciq_prs1[0], bus.ciq_prs2[0]); else n_pass++;
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL basic_no_early_grant got=%b exp=0000", bus.arbit_grant); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0001) $display("FAIL basic_grant got=%b exp=0001", bus.arbit_grant); else n_pass++;
    n_total++; if (bus.arbit_prd[0] !== 6'd10 || bus.arbit_addr[0] !== 4'd0) $display("FAIL basic_lane0 got prd=%0d addr=%0d exp prd=10 addr=0", bus.arbit_prd[0], bus.arbit_addr[0]); else n_pass++;
    n_total++; if (bus.arbit_prs1[0] !== 6'd5 || bus.arbit_prs2[0] !== 6'd6) $display("FAIL basic_srcs got=%0d/%0d exp=5/6", bus.arbit_prs1[0], bus.arbit_prs2[0]); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL basic_single_issue got=%b exp=0000", bus.arbit_grant); else n_pass++;
  endtask
  task automatic test_back_to_back();
    drain();
    disp(6'd0, 6'd0, 6'd12, 1'b1, 1'b1);
    tick();
    disp(6'd12, 6'd0, 6'd20, 1'b0, 1'b0);
    tick();
    clr();
    n_total++; if (bus.arbit_grant !== 4'b0001 || bus.arbit_prd[0] !== 6'd12) $display("FAIL b2b_producer got grant=%b prd=%0d exp grant=0001 prd=12", bus.arbit_grant, bus.arbit_prd[0]); else n_pass++;
    bus.prs1_rdy = 16'h0002;
    tick();
    clr();
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL b2b_gap got=%b exp=0000", bus.arbit_grant); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0001) $display("FAIL b2b_consumer_grant got=%b exp=0001", bus.arbit_grant); else n_pass++;
    n_total++; if (bus.arbit_prd[0] !== 6'd20 || bus.arbit_addr[0] !== 4'd1) $display("FAIL b2b_consumer_lane got prd=%0d addr=%0d exp prd=20 addr=1", bus.arbit_prd[0], bus.arbit_addr[0]); else n_pass++;
  endtask
  task automatic test_full();
    drain();
    for (int i = 0; i < 16; i++) begin
      disp(6'(i + 1), 6'd50, 6'(20 + i), 1'b0, 1'b0);
      tick();
    end
    disp(6'd60, 6'd61, 6'd63, 1'b1, 1'b1);
    #1;
    n_total++; if (bus.disp_ready !== 1'b0) $display("FAIL full_not_ready got=%b exp=0", bus.disp_ready); else n_pass++;
    tick();
    n_total++; if (bus.ciq_prs1[15] !== 6'd16 || bus.ciq_prs1[0] !== 6'd1) $display("FAIL full_no_overwrite got=%0d/%0d exp=16/1", bus.ciq_prs1[15], bus.ciq_prs1[0]); else n_pass++;
    clr();
    bus.prs1_rdy = 16'h0080; bus.prs2_rdy = 16'h0080;
    tick();
    clr();
    #1;
    n_total++; if (bus.arbit_grant !== 4'b0 || bus.disp_ready !== 1'b0) $display("FAIL full_wake_latch got grant=%b rdy=%b exp 0000/0", bus.arbit_grant, bus.disp_ready); else n_pass++;
    tick();
    #1;
    n_total++; if (bus.arbit_grant !== 4'b0001 || bus.arbit_addr[0] !== 4'd7) $display("FAIL full_grant7 got grant=%b addr=%0d exp 0001/7", bus.arbit_grant, bus.arbit_addr[0]); else n_pass++;
    n_total++; if (bus.arbit_prd[0] !== 6'd27) $display("FAIL full_prd7 got=%0d exp=27", bus.arbit_prd[0]); else n_pass++;
    n_total++; if (bus.disp_ready !== 1'b1) $display("FAIL full_slot_freed got=%b exp=1", bus.disp_ready); else n_pass++;
  endtask
  task automatic test_port_mask();
    drain();
    bus.fu_ready = 4'b0;
    for (int i = 0; i < 6; i++) begin
      disp(6'd0, 6'd0, 6'(40 + i), 1'b1, 1'b1);
      bus.fu_ready = 4'b0;
      tick();
    end
    clr();
    bus.fu_ready = 4'b1011;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b1011) $display("FAIL mask_grant1 got=%b exp=1011", bus.arbit_grant); else n_pass++;
    n_total++; if ({bus.arbit_addr[3], bus.arbit_addr[1], bus.arbit_addr[0]} !== {4'd2, 4'd1, 4'd0}) $display("FAIL mask_addr1 got=%0d,%0d,%0d exp=0,1,2", bus.arbit_addr[0], bus.arbit_addr[1], bus.arbit_addr[3]); else n_pass++;
    n_total++; if (bus.arbit_prd[3] !== 6'd42) $display("FAIL mask_prd_lane3 got=%0d exp=42", bus.arbit_prd[3]); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b1011) $display("FAIL mask_grant2 got=%b exp=1011", bus.arbit_grant); else n_pass++;
    n_total++; if ({bus.arbit_addr[3], bus.arbit_addr[1], bus.arbit_addr[0]} !== {4'd5, 4'd4, 4'd3}) $display("FAIL mask_addr2 got=%0d,%0d,%0d exp=3,4,5", bus.arbit_addr[0], bus.arbit_addr[1], bus.arbit_addr[3]); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL mask_empty got=%b exp=0000", bus.arbit_grant); else n_pass++;
  endtask
  task automatic test_bypass();
    drain();
    disp(6'd0, 6'd0, 6'd17, 1'b1, 1'b1);
    tick();
    clr();
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0001 || bus.arbit_prd[0] !== 6'd17) $display("FAIL byp_producer got grant=%b prd=%0d exp 0001/17", bus.arbit_grant, bus.arbit_prd[0]); else n_pass++;
    disp(6'd17, 6'd9, 6'd33, 1'b0, 1'b1);
    tick();
    clr();
    n_total++; if (bus.ciq_prs1[0] !== 6'd17 || bus.arbit_grant !== 4'b0) $display("FAIL byp_written got prs1=%0d grant=%b exp 17/0000", bus.ciq_prs1[0], bus.arbit_grant); else n_pass++;
    tick();
    n_total++; if (bus.arbit_grant !== 4'b0001 || bus.arbit_prd[0] !== 6'd33) $display("FAIL byp_consumer got grant=%b prd=%0d exp 0001/33", bus.arbit_grant, bus.arbit_prd[0]); else n_pass++;
  endtask
  task automatic test_flush();
    drain();
    for (int i = 0; i < 5; i++) begin
      disp(6'd0, 6'd0, 6'(1 + i), 1'b1, 1'b1);
      bus.fu_ready = 4'b0;
      tick();
    end
    disp(6'd0, 6'd0, 6'd7, 1'b1, 1'b1);
    bus.flush = 1'b1;
    #1;
    n_total++; if (bus.disp_ready !== 1'b0) $display("FAIL flush_blocks_disp got=%b exp=0", bus.disp_ready); else n_pass++;
    tick();
    clr();
    #1;
    n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL flush_grant got=%b exp=0000", bus.arbit_grant); else n_pass++;
    n_total++; if (bus.disp_ready !== 1'b1) $display("FAIL flush_ready got=%b exp=1", bus.disp_ready); else n_pass++;
    bus.prs1_rdy = '1; bus.prs2_rdy = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      clr();
      n_total++; if (bus.arbit_grant !== 4'b0) $display("FAIL flush_stale c=%0d got=%b exp=0000", c, bus.arbit_grant); else n_pass++;
    end
  endtask
  task automatic test_async_reset();
    drain();
    disp(6'd3, 6'd0, 6'd9, 1'b1, 1'b1);
    tick();
    disp(6'd4, 6'd0, 6'd10, 1'b1, 1'b1);
    tick();
    clr();
    n_total++; if (bus.arbit_grant !== 4'b0001 || bus.ciq_prs1[1] !== 6'd4) $display("FAIL arst_pre got grant=%b prs1=%0d exp 0001/4", bus.arbit_grant, bus.ciq_prs1[1]); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.arbit_grant !== 4'b0 || bus.arbit_prd[0] !== 6'd0) $display("FAIL arst_bus got grant=%b prd=%0d exp 0000/0", bus.arbit_grant, bus.arbit_prd[0]); else n_pass++;
    n_total++; if (bus.ciq_prs1[1] !== 6'd0) $display("FAIL arst_tags got=%0d exp=0", bus.ciq_prs1[1]); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.disp_ready !== 1'b1) $display("FAIL arst_ready got=%b exp=1", bus.disp_ready); else n_pass++;
  endtask
  task automatic test_random();
    int bl, bt;
    logic er;
    for (int c = 0; c < 400; c++) begin
      clr();
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.disp_valid = ($urandom_range(0, 3) != 0);
      bus.disp_prs1 = 6'($urandom_range(0, 15));
      bus.disp_prs2 = 6'($urandom_range(0, 15));
      bus.disp_prd = 6'($urandom_range(0, 15));
      bus.disp_prs1_rdy = ($urandom_range(0, 2) == 0);
      bus.disp_prs2_rdy = ($urandom_range(0, 2) == 0);
      bus.prs1_rdy = 16'($urandom) & 16'($urandom) & 16'($urandom);
      bus.prs2_rdy = 16'($urandom) & 16'($urandom) & 16'($urandom);
      bus.fu_ready = 4'($urandom);
      #1;
      er = exp_ready();
      n_total++; if (bus.disp_ready !== er) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.disp_ready, er); else n_pass++;
      tick();
      n_total++; if (bus.arbit_grant !== m_g) $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, bus.arbit_grant, m_g); else n_pass++;
      bl = -1;
      for (int k = 0; k < 4; k++)
        if (bl < 0 && m_g[k] && {bus.arbit_prd[k], bus.arbit_addr[k], bus.arbit_prs1[k], bus.arbit_prs2[k]} !== {m_prd[k], m_addr[k], m_s1[k], m_s2[k]}) bl = k;
      n_total++;
      if (bl >= 0) $display("FAIL rand_lane cyc=%0d lane=%0d got prd=%0d addr=%0d s1=%0d s2=%0d exp prd=%0d addr=%0d s1=%0d s2=%0d", c, bl, bus.arbit_prd[bl], bus.arbit_addr[bl], bus.arbit_prs1[bl], bus.arbit_prs2[bl], m_prd[bl], m_addr[bl], m_s1[bl], m_s2[bl]);
      else n_pass++;
      bt = -1;
      for (int i = 0; i < 16; i++)
        if (bt < 0 && m_v[i] && (bus.ciq_prs1[i] !== m_p1[i] || bus.ciq_prs2[i] !== m_p2[i])) bt = i;
      n_total++;
      if (bt >= 0) $display("FAIL rand_tags cyc=%0d entry=%0d got=%0d/%0d exp=%0d/%0d", c, bt, bus.ciq_prs1[bt], bus.ciq_prs2[bt], m_p1[bt], m_p2[bt]);
      else n_pass++;
    end
  endtask
  initial begin
    clr();
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_full();
    test_port_mask();
    test_bypass();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
